// File: rtl/branch_resolve_ctrl.sv
// branch_resolve_ctrl: in-order prediction queue between fetch and execute.
// Checks each resolved branch against the oldest queued prediction, sends a
// one-cycle update to the predictor, and on a mispredict flushes, redirects
// and holds fetch off for FLUSH_CYCLES cycles.
// Optional feature: define BRC_PERF_CNT_EN to add saturating branch and
// mispredict counters (perf_branches / perf_mispredicts).
module branch_resolve_ctrl #(
   parameter int PC_W         = 16,
   parameter int DEPTH        = 4,
   parameter int FLUSH_CYCLES = 2
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       pred_valid,
   input  logic [PC_W-1:0]            pred_pc,
   input  logic [PC_W-1:0]            pred_npc,
   output logic                       pred_ready,
   input  logic                       res_valid,
   input  logic                       res_taken,
   input  logic [PC_W-1:0]            res_npc,
   output logic                       upd_valid,
   output logic [PC_W-1:0]            upd_pc,
   output logic [PC_W-1:0]            upd_npc,
   output logic                       upd_taken,
   output logic                       flush,
   output logic                       redirect_valid,
   output logic [PC_W-1:0]            redirect_pc,
   output logic [$clog2(DEPTH+1)-1:0] count
`ifdef BRC_PERF_CNT_EN
   ,
   output logic [31:0]                perf_branches,
   output logic [31:0]                perf_mispredicts
`endif
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH+1);
   localparam int FW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

   typedef struct packed {
      logic [PC_W-1:0] pc;
      logic [PC_W-1:0] npc;
   } pred_t;

   typedef enum logic {RUN, FLUSH} state_t;

   state_t        state, state_nxt;
   logic [FW-1:0] fcnt, fcnt_nxt;
   pred_t         mem [DEPTH];
   logic [AW-1:0] head, tail;
   pred_t         head_e;
   logic          push, pop, mispred;

   assign head_e = mem[head];

   // Ready is suppressed while reset is held so every output reads 0 in reset;
   // no push-through when full, even if the head pops this cycle.
   assign pred_ready = rst && (state == RUN) && (count < CW'(DEPTH));
   assign push       = pred_valid & pred_ready;
   assign pop        = (state == RUN) & res_valid & (count != '0);
   assign mispred    = pop & (res_npc != head_e.npc);
   assign flush      = (state == FLUSH);

   // State register and flush-hold counter.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= RUN;
         fcnt  <= '0;
      end else begin
         state <= state_nxt;
         fcnt  <= fcnt_nxt;
      end
   end

   // Next state: a mispredict enters FLUSH, which lasts FLUSH_CYCLES cycles.
   always_comb begin
      state_nxt = state;
      fcnt_nxt  = fcnt;
      case (state)
         RUN: begin
            if (mispred) begin
               state_nxt = FLUSH;
               fcnt_nxt  = FW'(FLUSH_CYCLES-1);
            end
         end
         FLUSH: begin
            if (fcnt == '0) state_nxt = RUN;
            else            fcnt_nxt  = fcnt - FW'(1);
         end
         default: state_nxt = RUN;
      endcase
   end

   // Queue pointers and occupancy; a mispredict clears everything and the
   // same-cycle push is dropped.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else if (mispred) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else begin
         if (push) tail <= tail + AW'(1);
         if (pop)  head <= head + AW'(1);
         if (push && !pop)      count <= count + CW'(1);
         else if (pop && !push) count <= count - CW'(1);
      end
   end

   // Entry storage; contents are don't-care while the pointers say empty.
   always_ff @(posedge clk) begin
      if (push && !mispred) mem[tail] <= '{pc: pred_pc, npc: pred_npc};
   end

   // Registered predictor update and redirect, one cycle after the resolve.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         upd_valid      <= 1'b0;
         upd_pc         <= '0;
         upd_npc        <= '0;
         upd_taken      <= 1'b0;
         redirect_valid <= 1'b0;
         redirect_pc    <= '0;
      end else begin
         upd_valid      <= pop;
         upd_pc         <= pop ? head_e.pc : '0;
         upd_npc        <= pop ? res_npc : '0;
         upd_taken      <= pop & res_taken;
         redirect_valid <= mispred;
         redirect_pc    <= mispred ? res_npc : '0;
      end
   end

`ifdef BRC_PERF_CNT_EN
   // Saturating counters of accepted resolves and mispredicts.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         perf_branches    <= '0;
         perf_mispredicts <= '0;
      end else begin
         if (pop && perf_branches != 32'hFFFF_FFFF)
            perf_branches <= perf_branches + 32'd1;
         if (mispred && perf_mispredicts != 32'hFFFF_FFFF)
            perf_mispredicts <= perf_mispredicts + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_branch_resolve_ctrl.sv
// Bench for branch_resolve_ctrl: directed corner cases then random traffic,
// checked against a queue-level model with a decoupled update/redirect monitor.
module tb_branch_resolve_ctrl;
   localparam int PC_W = 16;
   localparam int DEPTH = 4;
   localparam int FC = 2;

   logic clk = 1'b0;
   logic rst = 1'b0;
   logic pred_valid = 1'b0, res_valid = 1'b0, res_taken = 1'b0;
   logic [PC_W-1:0] pred_pc = '0, pred_npc = '0, res_npc = '0;
   logic pred_ready, upd_valid, upd_taken, flush, redirect_valid;
   logic [PC_W-1:0] upd_pc, upd_npc, redirect_pc;
   logic [2:0] count;
`ifdef BRC_PERF_CNT_EN
   logic [31:0] perf_branches, perf_mispredicts;
   int exp_br = 0, exp_mis = 0;
`endif

   branch_resolve_ctrl #(.PC_W(PC_W), .DEPTH(DEPTH), .FLUSH_CYCLES(FC)) dut (
      .clk(clk), .rst(rst),
      .pred_valid(pred_valid), .pred_pc(pred_pc), .pred_npc(pred_npc), .pred_ready(pred_ready),
      .res_valid(res_valid), .res_taken(res_taken), .res_npc(res_npc),
      .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_npc(upd_npc), .upd_taken(upd_taken),
      .flush(flush), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .count(count)
`ifdef BRC_PERF_CNT_EN
      , .perf_branches(perf_branches), .perf_mispredicts(perf_mispredicts)
`endif
   );

   always #5 clk = ~clk;

   typedef struct packed { logic [PC_W-1:0] pc; logic [PC_W-1:0] npc; } ent_t;
   typedef struct {
      int              due;
      logic [PC_W-1:0] pc;
      logic [PC_W-1:0] npc;
      logic            taken;
      logic            redir;
   } exp_t;

   ent_t mq[$];        // model of the in-flight predictions, oldest first
   exp_t sb[$];        // expected update/redirect responses
   int   flush_left = 0;
   int   cyc = 0;
   int   total = 0, bad = 0;
   exp_t me;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Monitor: whenever a response is due the DUT must present it; otherwise idle.
   always @(negedge clk) begin
      if (sb.size() > 0 && sb[0].due == cyc) begin
         me = sb.pop_front();
         check("upd_valid", upd_valid, 1);
         check("upd_pc", upd_pc, me.pc);
         check("upd_npc", upd_npc, me.npc);
         check("upd_taken", upd_taken, me.taken);
         check("redirect_valid", redirect_valid, me.redir);
         if (me.redir) check("redirect_pc", redirect_pc, me.npc);
      end else begin
         check("upd_idle", upd_valid, 0);
         check("upd_taken_idle", upd_taken, 0);
         check("redirect_idle", redirect_valid, 0);
      end
   end

   // One cycle: check visible state against the model, then drive and advance the model.
   task automatic step(input logic pv, input logic [PC_W-1:0] pc, input logic [PC_W-1:0] npc,
                       input logic rv, input logic tk, input logic [PC_W-1:0] rn);
      logic exp_rdy;
      logic mis;
      int   sz;
      @(negedge clk);
      sz = mq.size();
      exp_rdy = (flush_left == 0) && (sz < DEPTH);
      check("pred_ready", pred_ready, exp_rdy);
      check("count", count, sz);
      check("flush", flush, flush_left > 0);
`ifdef BRC_PERF_CNT_EN
      check("perf_branches", perf_branches, exp_br);
      check("perf_mispredicts", perf_mispredicts, exp_mis);
`endif
      pred_valid = pv; pred_pc = pc; pred_npc = npc;
      res_valid = rv; res_taken = tk; res_npc = rn;
      if (flush_left > 0) begin
         flush_left--;
      end else if (rv && sz > 0) begin
         mis = (rn != mq[0].npc);
         sb.push_back('{due: cyc + 1, pc: mq[0].pc, npc: rn, taken: tk, redir: mis});
`ifdef BRC_PERF_CNT_EN
         exp_br++;
         if (mis) exp_mis++;
`endif
         if (mis) begin
            mq.delete();
            flush_left = FC;
         end else begin
            void'(mq.pop_front());
            if (pv && exp_rdy) mq.push_back('{pc: pc, npc: npc});
         end
      end else if (pv && exp_rdy) begin
         mq.push_back('{pc: pc, npc: npc});
      end
   endtask

   task automatic idle();
      step(0, '0, '0, 0, 0, '0);
   endtask

   task automatic push(input logic [PC_W-1:0] pc, input logic [PC_W-1:0] npc);
      step(1, pc, npc, 0, 0, '0);
   endtask

   // Resolve the head with its own predicted NPC (a correct prediction).
   task automatic resolve_ok(input logic tk);
      step(0, '0, '0, 1, tk, (mq.size() > 0) ? mq[0].npc : 16'h0);
   endtask

   // Mid-cycle asynchronous reset; outputs must clear without a clock edge.
   task automatic do_reset();
      #2;
      rst = 1'b0;
      pred_valid = 0; res_valid = 0;
      #1;
      check("rst_count", count, 0);
      check("rst_flush", flush, 0);
      check("rst_upd_valid", upd_valid, 0);
      check("rst_redirect", redirect_valid, 0);
      check("rst_pred_ready", pred_ready, 0);
      mq.delete(); sb.delete(); flush_left = 0;
`ifdef BRC_PERF_CNT_EN
      exp_br = 0; exp_mis = 0;
`endif
      @(negedge clk);
      rst = 1'b1;
   endtask

   initial begin
      logic [PC_W-1:0] rpc;
      logic [PC_W-1:0] rnpc;
      logic            pv, rv;
      // power-on reset
      #1;
      check("por_count", count, 0);
      check("por_pred_ready", pred_ready, 0);
      check("por_flush", flush, 0);
      check("por_upd_valid", upd_valid, 0);
      @(negedge clk);
      rst = 1'b1;

      // correct prediction
      push(16'h0010, 16'h0014);
      step(0, '0, '0, 1, 0, 16'h0014);
      idle(); idle();

      // fill to full, then resolve + push in the same cycle (push refused)
      for (int i = 0; i < 4; i++) push(16'h0100 + 16'(i*4), 16'h0104 + 16'(i*4));
      step(1, 16'h0200, 16'h0204, 1, 0, 16'h0104);
      idle();
      for (int i = 0; i < 3; i++) resolve_ok(1);
      idle();

      // mispredict with two entries queued
      push(16'h0020, 16'h0024);
      push(16'h0024, 16'h0028);
      step(0, '0, '0, 1, 1, 16'h0100);
      idle(); idle(); idle(); idle();

      // resolve on empty queue; push in the mispredict cycle
      step(0, '0, '0, 1, 1, 16'h0050);
      idle();
      push(16'h0030, 16'h0034);
      step(1, 16'h0040, 16'h0044, 1, 1, 16'h0999);
      idle(); idle(); idle(); idle();

      // five resolves, two of them mispredicting
      for (int i = 0; i < 5; i++) begin
         push(16'h0300 + 16'(i*8), 16'h0304 + 16'(i*8));
         if (i == 1 || i == 3) step(0, '0, '0, 1, 1, 16'h0700);
         else                  resolve_ok(0);
         idle(); idle(); idle();
      end

      // reset with three entries in flight
      push(16'h0400, 16'h0404);
      push(16'h0404, 16'h0408);
      push(16'h0408, 16'h040C);
      idle();
      do_reset();
      idle();

      // random traffic
      for (int n = 0; n < 600; n++) begin
         pv = ($urandom_range(0, 99) < 65);
         rv = ($urandom_range(0, 99) < 40);
         rpc = 16'($urandom);
         if (mq.size() > 0 && $urandom_range(0, 3) != 0) rnpc = mq[0].npc;
         else rnpc = 16'($urandom);
         step(pv, rpc, rpc + 16'd4, rv, 1'($urandom), rnpc);
      end

      for (int i = 0; i < 5; i++) idle();
      check("scoreboard_drained", sb.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
